// File: rtl/axis_nibble_downsizer.sv
// Splits 16-bit nibble-packed AXI-Stream words (tkeep = valid-bit count) into
// byte beats, most-significant valid nibble first. Optional stats: AXIS_DN_STATS_EN.
module axis_nibble_downsizer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [7:0]            s_axis_tkeep,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [7:0]            m_axis_tkeep
`ifdef AXIS_DN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [7:0]            err_cnt
`endif
);

  if (DATA_WIDTH != 16 || CNT_WIDTH < 1) begin : g_bad_cfg
    $error("axis_nibble_downsizer: only DATA_WIDTH=16 and CNT_WIDTH>=1 are supported");
  end

  typedef enum logic [1:0] {IDLE, FIRST, LAST} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic keep_illegal(input logic [7:0] k);
    return !(k == 8'd4 || k == 8'd8 || k == 8'd12 || k == 8'd16);
  endfunction

  state_t     state, state_n;
  logic [7:0] data_p1, data_n;
  logic [7:0] keep_p1, keep_n;
  logic       last_p1, last_n;
  logic [7:0] hold_p0, hold_n;
  logic [7:0] hkeep_p0, hkeep_n;
  logic       hlast_p0, hlast_n;
  logic       accept;

  assign s_axis_tready = !areset &&
                         ((state == IDLE) || (state == LAST && m_axis_tready));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (state != IDLE);
  assign m_axis_tdata  = data_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tlast  = last_p1;

  always_comb begin
    state_n = state;
    data_n  = data_p1;
    keep_n  = keep_p1;
    last_n  = last_p1;
    hold_n  = hold_p0;
    hkeep_n = hkeep_p0;
    hlast_n = hlast_p0;

    case (state)
      FIRST: if (m_axis_tready) begin
        state_n = LAST;
        data_n  = hold_p0;
        keep_n  = hkeep_p0;
        last_n  = hlast_p0;
      end
      LAST:    if (m_axis_tready && !accept) state_n = IDLE;
      default: ;
    endcase

    // A new word always overrides, including the hand-over from a consumed LAST beat
    if (accept) begin
      case (s_axis_tkeep)
        8'd12: begin
          data_n  = s_axis_tdata[11:4];
          keep_n  = 8'd8;
          last_n  = 1'b0;
          hold_n  = {4'h0, s_axis_tdata[3:0]};
          hkeep_n = 8'd4;
          hlast_n = s_axis_tlast;
          state_n = FIRST;
        end
        8'd8: begin
          data_n  = s_axis_tdata[7:0];
          keep_n  = 8'd8;
          last_n  = s_axis_tlast;
          state_n = LAST;
        end
        8'd4: begin
          data_n  = {4'h0, s_axis_tdata[3:0]};
          keep_n  = 8'd4;
          last_n  = s_axis_tlast;
          state_n = LAST;
        end
        default: begin
          data_n  = s_axis_tdata[15:8];
          keep_n  = 8'd8;
          last_n  = 1'b0;
          hold_n  = s_axis_tdata[7:0];
          hkeep_n = 8'd8;
          hlast_n = s_axis_tlast;
          state_n = FIRST;
        end
      endcase
    end
  end

  // Output stage: beat registers are cleared on reset so no stale beat survives
  always_ff @(posedge clk) begin
    if (areset) begin
      state   <= IDLE;
      data_p1 <= 8'h00;
      keep_p1 <= 8'h00;
      last_p1 <= 1'b0;
    end else begin
      state   <= state_n;
      data_p1 <= data_n;
      keep_p1 <= keep_n;
      last_p1 <= last_n;
    end
  end

  always_ff @(posedge clk) begin
    hold_p0  <= hold_n;
    hkeep_p0 <= hkeep_n;
    hlast_p0 <= hlast_n;
  end

`ifdef AXIS_DN_STATS_EN
  always_ff @(posedge clk) begin
    if (areset) begin
      pkt_cnt <= '0;
      err_cnt <= 8'h00;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + 1'b1;
      if (accept && keep_illegal(s_axis_tkeep))          err_cnt <= sat_inc8(err_cnt);
    end
  end
`endif

endmodule
